// File: rtl/i2c_cfg_arbiter.sv
// Round-robin arbiter sharing one 24-bit I2C write engine between two codec config ports.
// Optional NACK retry (WAIT -> GAP -> START) is built when I2C_ARB_RETRY_EN is defined.
module i2c_cfg_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        clock_i2c,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic        grant,
    output logic        busy,
    output logic        i2c_start,
    output logic [23:0] i2c_data,
    input  logic        i2c_tr_end,
    input  logic        i2c_ack
);

    localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
`ifdef I2C_ARB_RETRY_EN
        StGap,
`endif
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic [23:0]   data_q, data_d;
    logic          start_q, start_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          fin, fin_err;

`ifdef I2C_ARB_RETRY_EN
    localparam int unsigned RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    logic [RW-1:0] retry_q, retry_d;
    logic          gap_q, gap_d;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        data_d   = data_q;
        start_d  = start_q;
        done_d   = 2'b00;
        err_d    = 2'b00;
        to_cnt_d = to_cnt_q;
        fin      = 1'b0;
        fin_err  = 1'b0;
`ifdef I2C_ARB_RETRY_EN
        retry_d  = retry_q;
        gap_d    = gap_q;
`endif

        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // On a tie the port that was not served last wins.
                    grant_d = (req0 && req1) ? ~last_q : req1;
                    last_d  = grant_d;
                    data_d  = grant_d ? data1 : data0;
                    state_d = StStart;
                end
            end
            StStart: begin
                start_d  = 1'b1;
                to_cnt_d = '0;
                state_d  = StWait;
            end
            StWait: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // tr_end has priority over a coincident timeout.
                if (i2c_tr_end) begin
                    if (!i2c_ack) begin
                        fin = 1'b1;
                    end
`ifdef I2C_ARB_RETRY_EN
                    else if (retry_q < RETRY_LAST) begin
                        retry_d = retry_q + 1'b1;
                        gap_d   = 1'b0;
                        start_d = 1'b0;
                        state_d = StGap;
                    end
`endif
                    else begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
`ifdef I2C_ARB_RETRY_EN
            StGap: begin
                // Two low cycles; start is re-raised on the exit edge so the
                // engine sees exactly two cycles of start low between attempts.
                gap_d = 1'b1;
                if (gap_q) begin
                    start_d = 1'b1;
                    state_d = StStart;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
`ifdef I2C_ARB_RETRY_EN
                retry_d = '0;
`endif
            end
            default: state_d = StIdle;
        endcase

        if (fin) begin
            state_d         = StDone;
            start_d         = 1'b0;
            done_d[grant_q] = 1'b1;
            err_d[grant_q]  = fin_err;
        end
    end

    always_ff @(posedge clock_i2c or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            data_q   <= '0;
            start_q  <= 1'b0;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
            to_cnt_q <= '0;
`ifdef I2C_ARB_RETRY_EN
            retry_q  <= '0;
            gap_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            data_q   <= data_d;
            start_q  <= start_d;
            done_q   <= done_d;
            err_q    <= err_d;
            to_cnt_q <= to_cnt_d;
`ifdef I2C_ARB_RETRY_EN
            retry_q  <= retry_d;
            gap_q    <= gap_d;
`endif
        end
    end

    assign done0     = done_q[0];
    assign done1     = done_q[1];
    assign err0      = err_q[0];
    assign err1      = err_q[1];
    assign grant     = grant_q;
    assign busy      = (state_q != StIdle);
    assign i2c_start = start_q;
    assign i2c_data  = data_q;

endmodule

// File: doc/i2c_cfg_arbiter.md
# i2c_cfg_arbiter

Shares one 24-bit I2C write engine (frame `{dev_addr, reg_addr, reg_data}`, `start`/`tr_end`/`ack` handshake) between two codec register-config sequencers: port 0 for the ES8156 DAC and port 1 for the ADC. Arbitration is round-robin. The block adds per-transfer completion/error reporting, a hung-bus watchdog and optional NACK retry. It sits between the config sequencers and the engine, in the engine's clock domain.

## Interface

**Parameters**
- `TIMEOUT_CYC`, default 4096: `clock_i2c` cycles allowed in WAIT before the transfer is abandoned.
- `MAX_RETRY`, default 3: extra attempts after a NACK. Used only with `I2C_ARB_RETRY_EN`.

**Ports**
- `clock_i2c`  in  1: engine clock. All logic rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req0` / `req1`  in  1: level request. Held until `doneN` is sampled high.
- `data0` / `data1`  in  24: frame for each port. Must be stable while `reqN` is high.
- `done0` / `done1`  out  1: one-cycle pulse when the port's transfer has ended.
- `err0` / `err1`  out  1: asserted in the same cycle as `doneN` when the transfer failed (NACK or timeout).
- `grant`  out  1: index of the port currently or last served.
- `busy`  out  1: high in every state except IDLE.
- `i2c_start`  out  1: engine start. Held high until `i2c_tr_end`.
- `i2c_data`  out  24: latched frame driven to the engine.
- `i2c_tr_end`  in  1: engine transfer-end flag.
- `i2c_ack`  in  1: sampled with `i2c_tr_end`. 1 means at least one NACK occurred.

## Operation

- **Reset values:** all outputs 0. State is IDLE. Round-robin pointer `last` = 1, so port 0 wins the first tie. Retry and timeout counters are 0.
- **IDLE:**
  - One request high: grant that port.
  - Both high: grant `!last`.
  - On grant: latch `dataN` into `i2c_data`, set `grant`, set `last <= grant`, go to START.
- **START:** `i2c_start` = 1, clear the timeout counter, go to WAIT.
- **WAIT:** hold `i2c_start`. The timeout counter increments each cycle.
  - `i2c_tr_end` = 1 and `i2c_ack` = 0: go to DONE with ok.
  - `i2c_tr_end` = 1 and `i2c_ack` = 1: NACK handling (see Configuration).
  - Counter reaches `TIMEOUT_CYC - 1` with no `tr_end`: go to DONE with error.
  - If `tr_end` and the timeout hit in the same cycle, `tr_end` wins and its `ack` decides the outcome.
- **GAP (retry only):** `i2c_start` = 0 for exactly 2 cycles so the engine re-arms, then go to START. `i2c_data` is unchanged.
- **DONE:** `i2c_start` = 0. Pulse `done[grant]`, with `err[grant]` if failed. Clear the retry counter. Go to IDLE.
- **Requester contract:**
  - A requester drops `reqN` on the edge where it samples `doneN` = 1, so the following IDLE cycle sees it low.
  - A request still high in that IDLE cycle is treated as a new transfer.
- **Early request drop:** dropping `reqN` before `done` does not abort the transfer. It completes and `done` still pulses.
- The non-granted request waits. The port order is fixed by `last`, so neither port starves.

## Timing

- **Start latency:** `reqN` high in IDLE at edge k gives `i2c_start` high from edge k+2 (IDLE→START at k+1, start registered high at k+2).
- **Start release:** `i2c_start` drops the cycle after `i2c_tr_end` is sampled.
- **Completion:** `done` pulses one cycle after `tr_end` is sampled.
- **Minimum IDLE-to-IDLE:** 4 cycles plus engine transfer time.
- **Back-to-back:** after DONE, the other pending port is granted in the very next IDLE cycle. There is no idle gap beyond that single IDLE cycle.
- **Reset mid-transfer:** `i2c_start` and all outputs clear asynchronously. The engine aborts on `start` low. No `done` is issued for the aborted transfer.

## Configuration

- **`I2C_ARB_RETRY_EN` defined:**
  - A NACK with retry count < `MAX_RETRY` increments the count and goes WAIT→GAP→START.
  - When the count equals `MAX_RETRY`, go to DONE with error.
  - Worst case is `MAX_RETRY + 1` attempts.
  - The timeout counter restarts on every attempt.
- **Undefined:** a NACK goes directly to DONE with error. The GAP state and retry counter are not synthesised.

## Test plan

- **Single port:** `req0` = 1, `data0` = 24'h12_0205. Engine returns `tr_end`, `ack` = 0 after 30 cycles. Required: `i2c_start` high from k+2, `i2c_data` = 24'h120205, single `done0` pulse, `err0` = 0, `busy` back to 0.
- **Tie:** `req0` and `req1` rise in the same cycle after reset. Required: port 0 served first, then port 1 with no extra IDLE cycle. A second tie is served port 0 → port 1 again, since `last` = 1 after port 1.
- **NACK, retry enabled (`MAX_RETRY` = 3):** engine NACKs every attempt. Required: 4 `i2c_start` assertions, each separated by exactly 2 low cycles, then `done1` and `err1` high together. Without the macro: 1 attempt, then error.
- **Timeout (`TIMEOUT_CYC` = 16):** engine never asserts `tr_end`. Required: `i2c_start` drops 16 cycles after START, `done0` and `err0` pulse.
- **Reset mid-transfer:** assert `rst` in WAIT. Required: `i2c_start`, `busy`, `grant`, `done`, `err` all 0 asynchronously. After reset release, a held `req1` is granted normally.
- **`tr_end` on the timeout cycle:** `tr_end` with `ack` = 0 in the same cycle the counter hits the limit. Required: `done`, `err` = 0.
